mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / divide unit.
//
// A multiply runs a radix-2 Booth recurrence and a divide runs restoring division on the
// operand magnitudes. Both take one bit per cycle. The results are published on HI/LO with
// a one-cycle done pulse.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   mult_start  single-cycle request, signed op_a * op_b (wins over div_start)
//   div_start   single-cycle request, signed op_a / op_b
//   op_a        multiplicand / dividend, latched at start
//   op_b        multiplier / divisor, latched at start
//   busy        high in every state except idle, including the done cycle
//   done        one-cycle pulse, hi_out/lo_out valid
//   div_zero    one-cycle pulse alongside done when the divisor was zero
//   hi_out      mult: product upper half; div: remainder (sign of dividend)
//   lo_out      mult: product lower half; div: quotient (truncated toward zero)
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_e;

   state_e state_q, state_d;

   // The accumulator carries one guard bit so that subtracting a most-negative multiplicand
   // cannot overflow. In divide mode it holds the partial remainder, and its top bit stays 0.
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;        // multiplier (Booth) / quotient (divide)
   logic             q1_q, q1_d;        // Booth q[-1]
   logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand / divisor magnitude
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // One Booth step: add/subtract on {q0, q-1}, then arithmetic shift right of the pair.
   logic [WIDTH:0]   mcand_ext, booth_sum, booth_acc;
   logic [WIDTH-1:0] booth_mq;
   logic             booth_q1;

   always_comb begin
      mcand_ext = {mcand_q[WIDTH-1], mcand_q};
      case ({mq_q[0], q1_q})
         2'b01:   booth_sum = acc_q + mcand_ext;
         2'b10:   booth_sum = acc_q - mcand_ext;
         default: booth_sum = acc_q;
      endcase
      booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      booth_mq  = {booth_sum[0], mq_q[WIDTH-1:1]};
      booth_q1  = mq_q[0];
   end

   // One restoring-division step. The trial difference is negative exactly when bit WIDTH
   // is set, because the shifted remainder is always below twice the divisor.
   logic [WIDTH:0]   div_shift, div_trial, div_acc;
   logic [WIDTH-1:0] div_mq;

   always_comb begin
      div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, mcand_q};
      if (div_trial[WIDTH]) begin
         div_acc = div_shift;
         div_mq  = {mq_q[WIDTH-2:0], 1'b0};
      end else begin
         div_acc = div_trial;
         div_mq  = {mq_q[WIDTH-2:0], 1'b1};
      end
   end

   // Operand magnitudes. The most negative value maps onto itself, which is its correct
   // unsigned magnitude.
   logic [WIDTH-1:0] op_a_mag, op_b_mag, rem_mag, quo_fix, rem_fix;

   always_comb begin
      op_a_mag = op_a[WIDTH-1] ? -op_a : op_a;
      op_b_mag = op_b[WIDTH-1] ? -op_b : op_b;
      rem_mag  = acc_q[WIDTH-1:0];
      quo_fix  = neg_quo_q ? -mq_q : mq_q;
      rem_fix  = neg_rem_q ? -rem_mag : rem_mag;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (mult_start) begin
               state_d = StMult;
            end else if (div_start) begin
               state_d = (op_b == '0) ? StDone : StDiv;
            end
         end
         StMult:  if (cnt_q == LastCnt) state_d = StDone;
         StDiv:   if (cnt_q == LastCnt) state_d = StFix;
         StFix:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      busy     = (state_q != StIdle);
      done     = (state_q == StDone);
      div_zero = (state_q == StDone) && dz_q;
      hi_out   = hi_q;
      lo_out   = lo_q;
   end

   // Datapath next-state
   always_comb begin
      acc_d     = acc_q;
      mq_d      = mq_q;
      q1_d      = q1_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         StIdle: begin
            if (mult_start) begin
               acc_d   = '0;
               mq_d    = op_b;
               q1_d    = 1'b0;
               mcand_d = op_a;
               cnt_d   = '0;
            end else if (div_start && (op_b != '0)) begin
               acc_d     = '0;
               mq_d      = op_a_mag;
               mcand_d   = op_b_mag;
               cnt_d     = '0;
               neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
               neg_rem_d = op_a[WIDTH-1];
            end else if (div_start) begin
               dz_d = 1'b1;
            end
         end
         StMult: begin
            acc_d = booth_acc;
            mq_d  = booth_mq;
            q1_d  = booth_q1;
            cnt_d = cnt_q + CntW'(1);
            // Publish straight from the final step so HI/LO never show partial products.
            if (cnt_q == LastCnt) begin
               hi_d = booth_acc[WIDTH-1:0];
               lo_d = booth_mq;
            end
         end
         StDiv: begin
            acc_d = div_acc;
            mq_d  = div_mq;
            cnt_d = cnt_q + CntW'(1);
         end
         StFix: begin
            hi_d = rem_fix;
            lo_d = quo_fix;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q     <= '0;
         mq_q      <= '0;
         q1_q      <= 1'b0;
         mcand_q   <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         q1_q      <= q1_d;
         mcand_q   <= mcand_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule
